// File: rtl/cfg_pkg.sv
// Shared definitions for the sensor configuration LUT sequencer:
// the state encoding, the table terminator and the LUT word layout.
package cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DELAY,
    ST_FETCH,
    ST_WR,
    ST_RD,
    ST_RETRY,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } cfg_state_e;

  // A table entry with this register address ends the sequence.
  localparam logic [15:0] CFG_END_ADDR = 16'hffff;

  // LUT word layout: [24] unused, [23:8] register address, [7:0] data.
  localparam int LUT_ADDR_MSB = 23;
  localparam int LUT_ADDR_LSB = 8;
  localparam int LUT_DATA_MSB = 7;
  localparam int LUT_DATA_LSB = 0;

  function automatic logic is_terminator(input logic [15:0] addr);
    return addr == CFG_END_ADDR;
  endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// Loadable down-counter for the power-up settle delay. Once loaded with N
// and enabled, done is high during the N-th enabled cycle, so the caller
// spends exactly N cycles waiting. A load of 0 behaves like a load of 1.
module cfg_delay_cnt
  import cfg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count down from the loaded value while enabled, holding at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = en && (count <= WIDTH'(1));

endmodule

// File: rtl/lut_cfg_sequencer.sv
// Walks the sensor configuration LUT from index 0 and turns each
// {address, data} entry into a register write on the SCCB/I2C master,
// optionally reading it back for comparison. Failed entries are retried;
// the sequence ends in DONE (terminator or last index) or FAIL.
//
// Master handshake: i2c_req is a level held with i2c_rd/i2c_addr/i2c_wdata
// stable until the cycle i2c_ack is sampled high; it drops on the following
// cycle and stays low for at least one cycle before the next request. An
// i2c_ack that arrives while i2c_req is low is ignored.
module lut_cfg_sequencer
  import cfg_pkg::*;
#(
  parameter logic [31:0] INIT_DELAY_CYCLES = 32'd1_000_000,
  parameter logic [9:0]  LUT_MAX           = 10'd1023,
  parameter int          MAX_RETRY         = 3,
  parameter logic        VERIFY_EN         = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [9:0]  lut_index,
  input  logic [24:0] lut_data,
  output logic        i2c_req,
  output logic        i2c_rd,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_ack,
  input  logic        i2c_err,
  input  logic [7:0]  i2c_rdata,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [9:0]  err_index
);

  localparam logic [9:0] RETRY_LIMIT = 10'(MAX_RETRY);

  cfg_state_e  state;
  cfg_state_e  state_nxt;
  logic [15:0] entry_addr;
  logic [7:0]  entry_data;
  logic [9:0]  retry_cnt;
  logic        req_q;
  logic        delay_load;
  logic        delay_done;
  logic        xfer_ack;
  logic        retry_left;
  logic [15:0] lut_addr;
  logic [7:0]  lut_wdata;
  logic        lut_unused_bit;

  assign lut_addr       = lut_data[LUT_ADDR_MSB:LUT_ADDR_LSB];
  assign lut_wdata      = lut_data[LUT_DATA_MSB:LUT_DATA_LSB];
  assign lut_unused_bit = lut_data[24];

  // Only an acknowledge that lands on an outstanding request counts.
  assign xfer_ack   = req_q && i2c_ack;
  assign retry_left = retry_cnt < RETRY_LIMIT;

  cfg_delay_cnt #(
    .WIDTH(32)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (delay_load),
    .load_val(INIT_DELAY_CYCLES),
    .en      (state == ST_DELAY),
    .done    (delay_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; entering DELAY also reloads the settle counter.
  always_comb begin
    state_nxt  = state;
    delay_load = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt  = ST_DELAY;
        delay_load = 1'b1;
      end
      ST_DELAY: begin
        if (delay_done) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        state_nxt = is_terminator(lut_addr) ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        if (xfer_ack) begin
          if (i2c_err)        state_nxt = ST_RETRY;
          else if (VERIFY_EN) state_nxt = ST_RD;
          else                state_nxt = ST_NEXT;
        end
      end
      ST_RD: begin
        if (xfer_ack) begin
          if (i2c_err || (i2c_rdata != entry_data)) state_nxt = ST_RETRY;
          else                                      state_nxt = ST_NEXT;
        end
      end
      ST_RETRY: begin
        state_nxt = retry_left ? ST_WR : ST_FAIL;
      end
      ST_NEXT: begin
        state_nxt = (lut_index == LUT_MAX) ? ST_DONE : ST_FETCH;
      end
      ST_DONE, ST_FAIL: begin
        if (start) begin
          state_nxt  = ST_DELAY;
          delay_load = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Entry latch, index/retry bookkeeping and the request level. The request
  // is cleared on the acknowledge edge, so a WR->RD hand-over still leaves
  // one low cycle before the read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_index  <= '0;
      entry_addr <= '0;
      entry_data <= '0;
      retry_cnt  <= '0;
      err_index  <= '0;
      req_q      <= 1'b0;
    end else begin
      req_q <= ((state_nxt == ST_WR) || (state_nxt == ST_RD)) && !xfer_ack;
      if (state == ST_FETCH) begin
        entry_addr <= lut_addr;
        entry_data <= lut_wdata;
      end
      if (delay_load) begin
        lut_index <= '0;
        retry_cnt <= '0;
      end else if (state == ST_NEXT) begin
        retry_cnt <= '0;
        if (lut_index != LUT_MAX) lut_index <= lut_index + 10'd1;
      end else if (state == ST_RETRY) begin
        if (retry_left) retry_cnt <= retry_cnt + 10'd1;
        else            err_index <= lut_index;
      end
    end
  end

  assign i2c_req   = req_q;
  assign i2c_rd    = (state == ST_RD);
  assign i2c_addr  = entry_addr;
  assign i2c_wdata = entry_data;
  assign cfg_busy  = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_FAIL);
  assign cfg_done  = (state == ST_DONE);
  assign cfg_error = (state == ST_FAIL);

endmodule

// File: tb/tb_lut_cfg_sequencer.sv
// Bench for lut_cfg_sequencer. Two instances (write-only and verify) share
// one table and one behavioural I2C master; only the selected instance is
// out of reset. Expected transaction lists come from a table-walk model.
module tb_lut_cfg_sequencer;

  localparam int INIT_DLY = 10;
  localparam int LMAX     = 7;
  localparam int MRETRY   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a [2];
  logic        start;
  logic        i2c_ack;
  logic        i2c_err;
  logic [7:0]  i2c_rdata;
  logic [9:0]  idx_a   [2];
  logic [24:0] lut_a   [2];
  logic        req_a   [2];
  logic        rd_a    [2];
  logic [15:0] addr_a  [2];
  logic [7:0]  wdata_a [2];
  logic        busy_a  [2];
  logic        done_a  [2];
  logic        error_a [2];
  logic [9:0]  eidx_a  [2];

  logic [24:0] tbl [0:7];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lut_cfg_sequencer #(
      .INIT_DELAY_CYCLES(32'(INIT_DLY)),
      .LUT_MAX          (10'(LMAX)),
      .MAX_RETRY        (MRETRY),
      .VERIFY_EN        (g == 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_a[g]),
      .start    (start),
      .lut_index(idx_a[g]),
      .lut_data (lut_a[g]),
      .i2c_req  (req_a[g]),
      .i2c_rd   (rd_a[g]),
      .i2c_addr (addr_a[g]),
      .i2c_wdata(wdata_a[g]),
      .i2c_ack  (i2c_ack),
      .i2c_err  (i2c_err),
      .i2c_rdata(i2c_rdata),
      .cfg_busy (busy_a[g]),
      .cfg_done (done_a[g]),
      .cfg_error(error_a[g]),
      .err_index(eidx_a[g])
    );
    assign lut_a[g] = tbl[idx_a[g][2:0]];
  end

  // Selected-instance view.
  logic        sel;
  logic        m_rst, m_req, m_rd, m_busy, m_done, m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [9:0]  m_idx, m_eidx;
  always_comb begin
    m_rst   = rst_n_a[sel];
    m_req   = req_a[sel];
    m_rd    = rd_a[sel];
    m_addr  = addr_a[sel];
    m_wdata = wdata_a[sel];
    m_busy  = busy_a[sel];
    m_done  = done_a[sel];
    m_err   = error_a[sel];
    m_idx   = idx_a[sel];
    m_eidx  = eidx_a[sel];
  end

  // Stimulus configuration for the master.
  int fail_n    [0:7];   // failing attempts per entry
  int fail_kind [0:7];   // 0 write NACK, 1 read mismatch, 2 read NACK
  int lat;               // cycles of request before acknowledge
  bit spur_en;           // throw stray acknowledges while idle

  // Master observations.
  logic [24:0] obs_q[$];
  int          cyc, first_req_cyc, wait_cnt, hs_viol;
  int          att_cnt [0:7];
  bit          req_prev, ack_prev, busy_prev;
  logic [24:0] held;

  // Behavioural I2C master, acting on falling edges.
  always @(negedge clk) begin
    int ix, a;
    bit f;
    if (!m_rst) begin
      i2c_ack = 1'b0; i2c_err = 1'b0; i2c_rdata = 8'h00;
      cyc = 0; first_req_cyc = 0; wait_cnt = 0; hs_viol = 0;
      req_prev = 1'b0; ack_prev = 1'b0; busy_prev = 1'b0;
      obs_q.delete();
      for (int i = 0; i < 8; i++) att_cnt[i] = 0;
    end else begin
      cyc++;
      if (m_busy && !busy_prev) for (int i = 0; i < 8; i++) att_cnt[i] = 0;
      busy_prev = m_busy;
      if (ack_prev && m_req) begin
        hs_viol++;
        $display("[TB] handshake: request still high after acknowledge at cycle %0d", cyc);
      end
      i2c_ack = 1'b0;
      i2c_err = 1'b0;
      if (m_req) begin
        if (!req_prev) begin
          held     = {m_rd, m_addr, m_wdata};
          wait_cnt = 0;
          if (first_req_cyc == 0) first_req_cyc = cyc;
        end else if ({m_rd, m_addr, m_wdata} !== held) begin
          hs_viol++;
          $display("[TB] handshake: request fields changed at cycle %0d", cyc);
        end
        wait_cnt++;
        if (wait_cnt >= lat) begin
          ix = int'(m_idx[2:0]);
          obs_q.push_back({m_rd, m_addr, m_wdata});
          if (!m_rd) begin
            a = att_cnt[ix];
            att_cnt[ix]++;
            i2c_err   = (a < fail_n[ix]) && (fail_kind[ix] == 0);
            i2c_rdata = 8'($urandom);
          end else begin
            a = att_cnt[ix] - 1;
            f = (a < fail_n[ix]);
            i2c_err   = f && (fail_kind[ix] == 2);
            i2c_rdata = (f && fail_kind[ix] == 1) ? (tbl[ix][7:0] ^ 8'h01) : tbl[ix][7:0];
          end
          i2c_ack  = 1'b1;
          wait_cnt = 0;
        end
      end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
        i2c_ack = 1'b1;
        i2c_err = 1'($urandom_range(0, 1));
      end
      ack_prev = i2c_ack && m_req;
      req_prev = m_req;
    end
  end

  // Scoreboard: expected transactions {rd, addr, data} and final outcome.
  logic [24:0] exp_q[$];
  bit exp_done, exp_err;
  int exp_eidx, exp_last;
  int n_run, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 8; i++) begin
      fail_n[i]    = 0;
      fail_kind[i] = 0;
    end
  endtask

  // Walk the table: each entry gets up to 1+MRETRY attempts; a write NACK
  // ends an attempt after the write, a bad read-back after the read.
  task automatic build_expect(input bit verif);
    bit ok, f;
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 0; exp_last = 0;
    for (int i = 0; i <= LMAX; i++) begin
      exp_last = i;
      if (tbl[i][23:8] == 16'hffff) begin
        exp_done = 1'b1;
        break;
      end
      ok = 1'b0;
      for (int a = 0; a <= MRETRY; a++) begin
        f = (a < fail_n[i]);
        exp_q.push_back({1'b0, tbl[i][23:0]});
        if (f && fail_kind[i] == 0) continue;
        if (verif) exp_q.push_back({1'b1, tbl[i][23:0]});
        if (!f) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        exp_err  = 1'b1;
        exp_eidx = i;
        break;
      end
      if (i == LMAX) exp_done = 1'b1;
    end
  endtask

  task automatic rand_table(input bit verif, input bit use_term, input bit use_fail);
    int tpos;
    for (int i = 0; i < 8; i++) begin
      tbl[i] = {1'($urandom), 16'($urandom_range(0, 16'hfffe)), 8'($urandom)};
      fail_n[i]    = 0;
      fail_kind[i] = 0;
      if (use_fail) begin
        case ($urandom_range(0, 9))
          7, 8:    fail_n[i] = $urandom_range(1, 2);
          9:       fail_n[i] = 4;
          default: fail_n[i] = 0;
        endcase
        fail_kind[i] = verif ? $urandom_range(0, 2) : 0;
      end
    end
    if (use_term) begin
      tpos = $urandom_range(1, 7);
      tbl[tpos] = {1'b1, 16'hffff, 8'($urandom)};
    end
  endtask

  task automatic release_reset();
    step();
    rst_n_a[sel] = 1'b1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (m_done || m_err) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_finished"}, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lut_index"}, m_idx, 0);
    check({tag, "_req"}, m_req, 0);
    check({tag, "_rd"}, m_rd, 0);
    check({tag, "_addr"}, m_addr, 0);
    check({tag, "_wdata"}, m_wdata, 0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_error"}, m_err, 0);
    check({tag, "_err_index"}, m_eidx, 0);
  endtask

  task automatic check_result(input string tag, input int base);
    check({tag, "_done"}, m_done, 32'(exp_done));
    check({tag, "_error"}, m_err, 32'(exp_err));
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_lut_index"}, m_idx, exp_last);
    if (exp_err) check({tag, "_err_index"}, m_eidx, exp_eidx);
    check({tag, "_txn_count"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs_q.size()) check({tag, "_txn"}, obs_q[base + i], exp_q[i]);
    end
    check({tag, "_handshake_violations"}, hs_viol, 0);
  endtask

  initial begin
    int base;
    bit found;
    n_run = 0; n_fail = 0;
    sel = 1'b0;
    rst_n_a[0] = 1'b0; rst_n_a[1] = 1'b0;
    start = 1'b0;
    lat = 3; spur_en = 1'b0;
    clear_faults();
    for (int i = 0; i < 8; i++) tbl[i] = 25'h1ffffff;
    repeat (3) step();
    check_reset_vals("rst0");

    // Three-entry table with a terminator, fixed 3-cycle acknowledge.
    tbl[0] = 25'h0_0014_40;
    tbl[1] = 25'h0_00ff_01;
    tbl[2] = 25'h1_ffff_ff;
    build_expect(1'b0);
    release_reset();
    wait_end("t1");
    check_result("t1", 0);
    check("t1_first_req_not_early", 32'(first_req_cyc >= INIT_DLY + 1), 1);
    check("t1_first_req_not_late", 32'(first_req_cyc <= INIT_DLY + 3), 1);

    // One NACK at entry 0; restart from DONE; a start while busy is ignored.
    fail_n[0] = 1;
    build_expect(1'b0);
    base = obs_q.size();
    pulse_start();
    check("t2_restart_done_clr", m_done, 0);
    check("t2_restart_index", m_idx, 0);
    check("t2_restart_busy", m_busy, 1);
    repeat (20) step();
    pulse_start();
    check("t2_start_while_busy", m_busy, 1);
    wait_end("t2");
    check_result("t2", base);

    // Entry 1 NACKs every attempt: retries exhausted.
    clear_faults();
    fail_n[1] = 4;
    build_expect(1'b0);
    base = obs_q.size();
    pulse_start();
    wait_end("t3");
    check_result("t3", base);

    // Reset while the request for entry 1 is up, then a clean re-run.
    clear_faults();
    lat = 4;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (m_req && m_idx == 10'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_req_seen", 32'(found), 1);
    rst_n_a[0] = 1'b0;
    #1;
    check("t4_req_dropped", m_req, 0);
    check("t4_busy_dropped", m_busy, 0);
    check("t4_index_cleared", m_idx, 0);
    check("t4_addr_cleared", m_addr, 0);
    repeat (2) step();
    build_expect(1'b0);
    release_reset();
    wait_end("t4");
    check_result("t4", 0);
    check("t4_full_delay", 32'(first_req_cyc >= INIT_DLY + 1), 1);

    // Randomised tables, latencies and stray acknowledges (write-only).
    for (int k = 0; k < 4; k++) begin
      rand_table(1'b0, k != 0, k != 0);
      lat = $urandom_range(1, 4);
      spur_en = 1'b1;
      build_expect(1'b0);
      base = obs_q.size();
      pulse_start();
      wait_end("rnd_wr");
      check_result("rnd_wr", base);
    end

    // Switch to the verifying instance.
    step();
    rst_n_a[0] = 1'b0;
    sel = 1'b1;
    repeat (2) step();
    check_reset_vals("rst1");
    spur_en = 1'b0;
    lat = 3;
    clear_faults();
    tbl[0] = 25'h0_0014_40;
    tbl[1] = 25'h0_ffff_00;
    fail_n[0] = 1;
    fail_kind[0] = 1;
    build_expect(1'b1);
    release_reset();
    wait_end("t5");
    check_result("t5", 0);

    // Terminator at index 0: no bus traffic.
    clear_faults();
    tbl[0] = 25'h0_ffff_12;
    build_expect(1'b1);
    base = obs_q.size();
    pulse_start();
    wait_end("t6");
    check_result("t6", base);

    // Randomised verify runs with all failure kinds.
    for (int k = 0; k < 4; k++) begin
      rand_table(1'b1, k != 0, 1'b1);
      lat = $urandom_range(1, 4);
      spur_en = 1'b1;
      build_expect(1'b1);
      base = obs_q.size();
      pulse_start();
      wait_end("rnd_vf");
      check_result("rnd_vf", base);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
